// File: rtl/out_slot_arbiter.sv
// out_slot_arbiter: 4-requester round-robin slot arbiter driving one shared
// 8-bit output bus. A granted requester owns the bus for DWELL enabled cycles,
// or less if it drops its request. Every slot is followed by at least one idle
// cycle.
// Optional build macro IDLE_PATTERN_EN: while idle, out_data shows a rotating
// pattern register. Without the macro the idle bus reads 8'h00.
module out_slot_arbiter #(
  parameter int unsigned DWELL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic [7:0]  out_data,
  output logic        out_valid
);

  typedef enum logic {IDLE, SLOT} state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t      state, state_nx;
  logic [3:0]  grant_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [1:0]  ptr, ptr_nx;
  logic [3:0]  done_r, done_nx;
  logic        win_found;
  logic [1:0]  win_idx;
  logic [1:0]  idx;

  // Round-robin search starting at ptr; the first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    idx       = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Next-state logic. A full-length end takes priority over an early end.
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    done_nx  = '0;
    if (ena) begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state_nx = SLOT;
            grant_nx = 4'b0001 << win_idx;
            cnt_nx   = '0;
            ptr_nx   = win_idx + 2'd1;
          end
        end
        SLOT: begin
          if (cnt == LAST) begin
            state_nx = IDLE;
            grant_nx = '0;
            done_nx  = grant;
          end else if ((req & grant) == '0) begin
            state_nx = IDLE;
            grant_nx = '0;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State registers. Reset overrides everything, including ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      cnt    <= '0;
      ptr    <= '0;
      done_r <= '0;
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      cnt    <= cnt_nx;
      ptr    <= ptr_nx;
      done_r <= done_nx;
    end
  end

  assign done      = done_r & {4{ena}};
  assign out_valid = (state == SLOT);

`ifdef IDLE_PATTERN_EN
  logic [7:0] pattern;

  // Idle pattern rotates left once per enabled idle cycle and holds during a slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern <= 8'hAA;
    end else if (ena && state == IDLE) begin
      pattern <= {pattern[6:0], pattern[7]};
    end
  end
`endif

  // Output bus: the grantee's slice while in a slot, the idle value otherwise.
  always_comb begin
    out_data = 8'h00;
    if (state == SLOT) begin
      case (grant)
        4'b0001: out_data = data[7:0];
        4'b0010: out_data = data[15:8];
        4'b0100: out_data = data[23:16];
        4'b1000: out_data = data[31:24];
        default: out_data = 8'h00;
      endcase
    end else begin
`ifdef IDLE_PATTERN_EN
      out_data = pattern;
`else
      out_data = 8'h00;
`endif
    end
  end

endmodule

// File: doc/out_slot_arbiter.md
OUT_SLOT_ARBITER -- requirements
Module: out_slot_arbiter

Interface
REQ-001 The module SHALL have parameter DWELL, default 4, giving slot length in enabled clk cycles; legal range 1..255.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The module SHALL have port ena, input, 1, global enable; low freezes all state.
REQ-005 The module SHALL have port req, input, 4, one request bit per requester 0..3.
REQ-006 The module SHALL have port data, input, 32, requester n payload on data[8n+7:8n].
REQ-007 The module SHALL have port grant, output, 4, one-hot or zero, current slot owner.
REQ-008 The module SHALL have port done, output, 4, one-cycle pulse for the requester whose slot completed at full length.
REQ-009 The module SHALL have port out_data, output, 8, the shared output bus.
REQ-010 The module SHALL have port out_valid, output, 1, high while a slot is active.

Function
REQ-011 The FSM SHALL have states IDLE and SLOT; out_valid is high exactly in SLOT.
REQ-012 IDLE with any req bit high at a rising edge SHALL transition to SLOT, registering grant, so grant appears one cycle after req is sampled.
REQ-013 Winner selection SHALL be round-robin: search starts at pointer ptr and proceeds ptr, ptr+1, ... mod 4; first set req bit wins.
REQ-014 On grant, ptr SHALL become (winner+1) mod 4.
REQ-015 An 8-bit slot counter SHALL load 0 on entry to SLOT and increment each enabled cycle in SLOT.
REQ-016 SLOT SHALL return to IDLE when counter equals DWELL-1 (full-length slot, exactly DWELL cycles) or when req of the grantee is sampled low (early end); grant clears with the transition.
REQ-017 If both end conditions hold in the same cycle, the slot SHALL count as full-length.
REQ-018 Every slot SHALL be followed by at least one IDLE cycle; no back-to-back grants.
REQ-019 done[n] SHALL be high for exactly the first IDLE cycle after a full-length slot of requester n; early-ended slots produce no done.
REQ-020 In SLOT, out_data SHALL equal the grantee's current data slice (combinational from grant register).
REQ-021 Changes of non-granted req bits during SLOT SHALL have no effect until IDLE.
REQ-022 With ena low, state, counter, ptr, grant and pattern SHALL hold; done SHALL be forced 0; out_data and out_valid reflect held state.
REQ-023 DWELL=1 SHALL give single-cycle slots.

Reset
REQ-024 When rst is high at a rising edge, the state SHALL become IDLE, with grant=0, done=0, counter=0, ptr=0 and out_valid=0, regardless of ena.
REQ-025 Reset during SLOT SHALL abort the slot with no done pulse.
REQ-026 rst SHALL take priority over all other inputs.

Configuration
REQ-027 Macro IDLE_PATTERN_EN defined: outside SLOT, out_data SHALL equal an 8-bit pattern register, reset 8'hAA, rotated left by 1 every enabled cycle spent in IDLE; the register holds during SLOT.
REQ-028 Macro IDLE_PATTERN_EN undefined: outside SLOT, out_data SHALL be 8'h00 and no pattern register exists.

Verification (DWELL=4)
REQ-029 Scenario 1: reset, then req=4'b0010 held, data[15:8]=8'h5C -> grant=4'b0010 one cycle later; out_valid and out_data=8'h5C for 4 cycles; then one IDLE cycle with done=4'b0010; regrant follows.
REQ-030 Scenario 2: req=4'b1111 held after reset -> grant order 0,1,2,3,0, each slot 4 cycles separated by 1 IDLE cycle, with done pulsing for each requester.
REQ-031 Scenario 3: req0 granted, req0 dropped in slot cycle 2 -> grant clears next edge; no done; ptr=1.
REQ-032 Scenario 4: rst pulsed in slot cycle 3 of requester 2 -> grant=0, done=0, out_valid=0 next cycle; with req=4'b0101 held, the next grant goes to requester 0.
REQ-033 Scenario 5: ena low for 3 cycles mid-slot -> grant, out_data and counter hold; the slot still totals 4 enabled cycles.
REQ-034 Scenario 6: req=0 after reset with IDLE_PATTERN_EN defined -> out_data 8'hAA, 8'h55, 8'hAA on successive cycles; with the macro undefined -> out_data=8'h00.
